// File: rtl/mem_rd_ctrl.sv
// Read-side controller for the accumulator processor's data memory.
// Runs a req/ack handshake with a bounded wait and latches the returned nibble.
//
// state | meaning
// IDLE  | waiting for rd_req; busy low
// WAIT  | mem_rd asserted, waiting for mem_ack or timeout
// DONE  | one-cycle rd_done pulse, data_out already updated
// ERR   | one-cycle rd_err pulse, data_out untouched
module mem_rd_ctrl #(
  parameter int AW      = 8,
  parameter int DW      = 4,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_addr,
  output logic          busy,
  output logic          mem_rd,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_data,
  output logic [DW-1:0] data_out,
  output logic          rd_done,
  output logic          rd_err
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] wait_cnt;
  logic          accept;
  logic          ack_hit;
  logic          timeout_hit;

  // Ack is evaluated ahead of the timeout so an ack on the last allowed cycle wins.
  assign accept      = (state == S_IDLE) && rd_req;
  assign ack_hit     = (state == S_WAIT) && mem_ack;
  assign timeout_hit = (state == S_WAIT) && !mem_ack && (wait_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (clr) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = S_WAIT;
      S_WAIT: begin
        if (ack_hit) begin
          state_nxt = S_DONE;
        end else if (timeout_hit) begin
          state_nxt = S_ERR;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      S_ERR:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy    = 1'b0;
    mem_rd  = 1'b0;
    rd_done = 1'b0;
    rd_err  = 1'b0;
    case (state)
      S_WAIT: begin
        busy   = 1'b1;
        mem_rd = 1'b1;
      end
      S_DONE: begin
        busy    = 1'b1;
        rd_done = 1'b1;
      end
      S_ERR: begin
        busy   = 1'b1;
        rd_err = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath: address latch, wait counter and captured read data.
  always_ff @(posedge clk) begin
    if (clr) begin
      mem_addr <= '0;
      data_out <= '0;
      wait_cnt <= '0;
    end else begin
      if (accept) begin
        mem_addr <= rd_addr;
        wait_cnt <= '0;
      end else if (ack_hit) begin
        data_out <= mem_data;
      end else if ((state == S_WAIT) && (wait_cnt != CNT_LAST)) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_rd_ctrl.sv
// Directed self-checking bench for mem_rd_ctrl (AW=8, DW=4, TIMEOUT=15).
module tb_mem_rd_ctrl;

  logic       clk = 1'b0;
  logic       clr;
  logic       rd_req;
  logic [7:0] rd_addr;
  logic       busy;
  logic       mem_rd;
  logic [7:0] mem_addr;
  logic       mem_ack;
  logic [3:0] mem_data;
  logic [3:0] data_out;
  logic       rd_done;
  logic       rd_err;

  int tests = 0;
  int fails = 0;

  mem_rd_ctrl #(.AW(8), .DW(4), .TIMEOUT(15)) dut (
    .clk      (clk),
    .clr      (clr),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .busy     (busy),
    .mem_rd   (mem_rd),
    .mem_addr (mem_addr),
    .mem_ack  (mem_ack),
    .mem_data (mem_data),
    .data_out (data_out),
    .rd_done  (rd_done),
    .rd_err   (rd_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, answer with ack on the ack_at-th mem_rd cycle (0 = never),
  // and count strobe/pulse cycles until busy falls or the cycle budget expires.
  task automatic run_read(input logic [7:0] addr, input int ack_at, input logic [3:0] data,
                          output int rd_cyc, output int done_cyc, output int err_cyc,
                          output logic timed_out);
    rd_req  = 1'b1;
    rd_addr = addr;
    step();
    rd_req   = 1'b0;
    rd_cyc   = 0;
    done_cyc = 0;
    err_cyc  = 0;
    timed_out = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (mem_rd) rd_cyc++;
      if (rd_done) done_cyc++;
      if (rd_err) err_cyc++;
      if (!busy) begin
        timed_out = 1'b0;
        break;
      end
      mem_ack  = mem_rd && (ack_at != 0) && (rd_cyc == ack_at);
      mem_data = data;
      step();
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    clr = 1'b1; rd_req = 1'b1; rd_addr = 8'hFF; mem_ack = 1'b1; mem_data = 4'hF;
    step();
    step();
    tests++;
    if ({busy, mem_rd, mem_addr, data_out, rd_done, rd_err} !== 16'h0) begin
      fails++;
      $display("FAIL reset_outputs: got busy=%b mem_rd=%b mem_addr=%h data_out=%h done=%b err=%b, want all 0",
               busy, mem_rd, mem_addr, data_out, rd_done, rd_err);
    end
    clr = 1'b0; rd_req = 1'b0; mem_ack = 1'b0;
    step();
    tests++;
    if ({busy, mem_rd} !== 2'b00) begin
      fails++;
      $display("FAIL reset_idle: got busy=%b mem_rd=%b, want 0 0", busy, mem_rd);
    end
  endtask

  task automatic test_zero_wait();
    rd_req = 1'b1; rd_addr = 8'h3A;
    step();
    rd_req = 1'b0; rd_addr = 8'h00;
    tests++;
    if ({mem_rd, busy, mem_addr, rd_done} !== {1'b1, 1'b1, 8'h3A, 1'b0}) begin
      fails++;
      $display("FAIL zw_issue: got mem_rd=%b busy=%b mem_addr=%h done=%b, want 1 1 3a 0",
               mem_rd, busy, mem_addr, rd_done);
    end
    mem_ack = 1'b1; mem_data = 4'hC;
    step();
    mem_ack = 1'b0; mem_data = 4'h0;
    tests++;
    if ({mem_rd, busy, data_out, rd_done, rd_err} !== {1'b0, 1'b1, 4'hC, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL zw_done: got mem_rd=%b busy=%b data_out=%h done=%b err=%b, want 0 1 c 1 0",
               mem_rd, busy, data_out, rd_done, rd_err);
    end
    step();
    tests++;
    if ({busy, rd_done, data_out, mem_addr} !== {1'b0, 1'b0, 4'hC, 8'h3A}) begin
      fails++;
      $display("FAIL zw_idle: got busy=%b done=%b data_out=%h mem_addr=%h, want 0 0 c 3a",
               busy, rd_done, data_out, mem_addr);
    end
  endtask

  task automatic test_delayed_ack();
    int r, d, e;
    logic to;
    run_read(8'h55, 6, 4'h7, r, d, e, to);
    tests++;
    if (to !== 1'b0 || r != 6 || d != 1 || e != 0) begin
      fails++;
      $display("FAIL delayed_ack: got timeout=%b mem_rd_cycles=%0d done=%0d err=%0d, want 0 6 1 0", to, r, d, e);
    end
    tests++;
    if (data_out !== 4'h7) begin
      fails++;
      $display("FAIL delayed_data: got %h, want 7", data_out);
    end
  endtask

  task automatic test_timeout();
    int r, d, e;
    logic to;
    run_read(8'h66, 0, 4'h1, r, d, e, to);
    tests++;
    if (to !== 1'b0 || r != 15 || d != 0 || e != 1) begin
      fails++;
      $display("FAIL timeout: got timeout=%b mem_rd_cycles=%0d done=%0d err=%0d, want 0 15 0 1", to, r, d, e);
    end
    tests++;
    if (data_out !== 4'h7) begin
      fails++;
      $display("FAIL timeout_data_held: got %h, want 7", data_out);
    end
  endtask

  task automatic test_boundary_ack();
    int r, d, e;
    logic to;
    run_read(8'h77, 15, 4'hA, r, d, e, to);
    tests++;
    if (to !== 1'b0 || r != 15 || d != 1 || e != 0) begin
      fails++;
      $display("FAIL boundary_ack: got timeout=%b mem_rd_cycles=%0d done=%0d err=%0d, want 0 15 1 0", to, r, d, e);
    end
    tests++;
    if (data_out !== 4'hA) begin
      fails++;
      $display("FAIL boundary_data: got %h, want a", data_out);
    end
  endtask

  task automatic test_busy_ignore();
    int dones = 0;
    int rds = 0;
    rd_req = 1'b1; rd_addr = 8'h21;
    step();
    rd_req = 1'b0;
    step();
    rd_req = 1'b1; rd_addr = 8'hEE;
    step();
    rd_req = 1'b0;
    tests++;
    if ({mem_rd, mem_addr} !== {1'b1, 8'h21}) begin
      fails++;
      $display("FAIL busy_addr_hold: got mem_rd=%b mem_addr=%h, want 1 21", mem_rd, mem_addr);
    end
    mem_ack = 1'b1; mem_data = 4'h3;
    step();
    mem_ack = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (rd_done) dones++;
      if (mem_rd) rds++;
      step();
    end
    tests++;
    if (dones != 1 || rds != 0 || data_out !== 4'h3 || mem_addr !== 8'h21 || busy !== 1'b0) begin
      fails++;
      $display("FAIL busy_ignore: got dones=%0d extra_rd=%0d data_out=%h mem_addr=%h busy=%b, want 1 0 3 21 0",
               dones, rds, data_out, mem_addr, busy);
    end
  endtask

  task automatic test_back_to_back();
    rd_req = 1'b1; rd_addr = 8'h88;
    step();
    rd_req = 1'b0;
    mem_ack = 1'b1; mem_data = 4'h9;
    step();
    mem_ack = 1'b0;
    rd_req = 1'b1; rd_addr = 8'h11;  // lands on DONE: must be dropped
    step();
    tests++;
    if ({busy, mem_addr} !== {1'b0, 8'h88}) begin
      fails++;
      $display("FAIL b2b_done_req: got busy=%b mem_addr=%h, want 0 88", busy, mem_addr);
    end
    rd_addr = 8'h90;
    step();
    rd_req = 1'b0;
    tests++;
    if ({mem_rd, busy, mem_addr, data_out} !== {1'b1, 1'b1, 8'h90, 4'h9}) begin
      fails++;
      $display("FAIL b2b_accept: got mem_rd=%b busy=%b mem_addr=%h data_out=%h, want 1 1 90 9",
               mem_rd, busy, mem_addr, data_out);
    end
    mem_ack = 1'b1; mem_data = 4'h5;
    step();
    mem_ack = 1'b0;
    tests++;
    if ({rd_done, data_out} !== {1'b1, 4'h5}) begin
      fails++;
      $display("FAIL b2b_second: got done=%b data_out=%h, want 1 5", rd_done, data_out);
    end
    step();
  endtask

  task automatic test_abort();
    int pulses = 0;
    rd_req = 1'b1; rd_addr = 8'h42;
    step();
    rd_req = 1'b0;
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    tests++;
    if ({mem_rd, busy, rd_done, rd_err, data_out, mem_addr} !== 16'h0) begin
      fails++;
      $display("FAIL abort: got mem_rd=%b busy=%b done=%b err=%b data_out=%h mem_addr=%h, want all 0",
               mem_rd, busy, rd_done, rd_err, data_out, mem_addr);
    end
    mem_ack = 1'b1; mem_data = 4'hF;
    for (int c = 0; c < 20; c++) begin
      if (rd_done || rd_err || mem_rd) pulses++;
      step();
    end
    mem_ack = 1'b0;
    tests++;
    if (pulses != 0 || data_out !== 4'h0) begin
      fails++;
      $display("FAIL abort_quiet: got pulses=%0d data_out=%h, want 0 0", pulses, data_out);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    clr = 1'b1; rd_req = 1'b0; rd_addr = '0; mem_ack = 1'b0; mem_data = '0;
    test_reset();
    test_zero_wait();
    test_delayed_ack();
    test_timeout();
    test_boundary_ack();
    test_busy_ignore();
    test_back_to_back();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
